// File: rtl/sorter_pkg.sv
// Shared sorter types: element/set widths, lane indexing, pad value.
// Used by the set packer, its interface and the sorter core.
package sorter_pkg;

  localparam int ELEM_W = 8;
  localparam int N_ELEM = 9;
  localparam int SET_W  = N_ELEM * ELEM_W;
  localparam int CNT_W  = $clog2(N_ELEM);

  typedef logic [ELEM_W-1:0] elem_t;
  typedef logic [SET_W-1:0]  set_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam elem_t PAD_VAL = {ELEM_W{1'b1}};

  // MSB of lane k; lane 0 is the top byte of the set word
  function automatic int lane_msb(int k);
    return SET_W - 1 - k * ELEM_W;
  endfunction

endpackage

// File: rtl/sort_set_packer_if.sv
// Byte-in / set-out bundle of the sorter set packer.
// PACK_PAD_EN adds lastIn (short-set terminator, qualified by validIn).
interface sort_set_packer_if;

  logic [sorter_pkg::ELEM_W-1:0] dataIn;
  logic                          validIn;
  logic                          readyOut;
  logic                          flush;
  logic [sorter_pkg::SET_W-1:0]  setOut;
  logic                          setValid;
  logic                          setReady;
`ifdef PACK_PAD_EN
  logic                          lastIn;

  modport master (
    output dataIn, validIn, flush, setReady, lastIn,
    input  readyOut, setOut, setValid
  );
  modport slave (
    input  dataIn, validIn, flush, setReady, lastIn,
    output readyOut, setOut, setValid
  );
`else
  modport master (
    output dataIn, validIn, flush, setReady,
    input  readyOut, setOut, setValid
  );
  modport slave (
    input  dataIn, validIn, flush, setReady,
    output readyOut, setOut, setValid
  );
`endif

endinterface

// File: rtl/sort_set_outreg.sv
// Set holding register with valid/ready hand-off from an upstream
// buffer. Ports: din/din_valid/din_take upstream, dout/dout_valid/dout_ready down.
module sort_set_outreg
  import sorter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  set_t din,
  input  logic din_valid,
  output logic din_take,
  output set_t dout,
  output logic dout_valid,
  input  logic dout_ready
);

  // Load when empty or when the held set leaves this same cycle
  assign din_take = din_valid & (~dout_valid | dout_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (din_take) begin
      dout       <= din;
      dout_valid <= 1'b1;
    end else if (dout_valid & dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sort_set_packer.sv
// Packs a byte stream into N_ELEM-lane sets for the sorter, first byte
// in the MSB lane. Ports: clk, rst (sync, high), bus (slave). Macro: PACK_PAD_EN.
module sort_set_packer
  import sorter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  sort_set_packer_if.slave    bus
);

  cnt_t cnt;
  logic asm_full;
  set_t asm_q;
  logic take;
  logic acc;
  logic fin;

  // Ready depends only on registered state, never on setReady
  assign bus.readyOut = ~asm_full & ~rst;
  assign acc = bus.validIn & bus.readyOut;

`ifdef PACK_PAD_EN
  assign fin = (cnt == cnt_t'(N_ELEM - 1)) | bus.lastIn;
`else
  assign fin = (cnt == cnt_t'(N_ELEM - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      asm_full <= 1'b0;
    end else begin
      if (take)
        asm_full <= 1'b0;
      // flush drops any byte accepted in the same cycle
      if (bus.flush) begin
        cnt <= '0;
      end else if (acc) begin
        for (int j = 0; j < N_ELEM; j++) begin
          if (cnt_t'(j) == cnt)
            asm_q[lane_msb(j) -: ELEM_W] <= bus.dataIn;
`ifdef PACK_PAD_EN
          else if (bus.lastIn && (cnt_t'(j) > cnt))
            asm_q[lane_msb(j) -: ELEM_W] <= PAD_VAL;
`endif
        end
        if (fin) begin
          cnt      <= '0;
          asm_full <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  sort_set_outreg u_outreg (
    .clk        (clk),
    .rst        (rst),
    .din        (asm_q),
    .din_valid  (asm_full),
    .din_take   (take),
    .dout       (bus.setOut),
    .dout_valid (bus.setValid),
    .dout_ready (bus.setReady)
  );

endmodule
